// File: rtl/div_iter_u32.sv
// Multi-cycle unsigned radix-2 restoring divider.
// Accepts one operation at a time while idle and returns {quotient, remainder}
// with a one-cycle m_valid pulse after a fixed WIDTH-step latency. A zero
// divisor bypasses the iteration and returns {all-ones, dividend}.
module div_iter_u32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               m_valid,
  output logic [2*WIDTH-1:0] m_data,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_step;
  logic             accept;

  assign s_ready   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = s_valid && (state_q == IDLE);
  assign last_step = (count_q == CW'(WIDTH - 1));

  // One restoring step: shift {rem, quo} left, try subtracting the divisor,
  // keep the difference only when it did not go negative.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor_q};
    rem_next  = trial[WIDTH] ? rem_shift : trial;
    quo_next  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. DONE is left only once the result pulse has been shown;
  // the divide-by-zero path enters DONE with m_valid still low and raises it
  // on the following edge.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
      CALC: if (last_step) state_d = DONE;
      DONE: if (m_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, iteration in CALC, result presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      count_q   <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            divisor_q <= divisor;
            quo_q     <= dividend;
            rem_q     <= '0;
            count_q   <= '0;
          end
        end
        CALC: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q + 1'b1;
          if (last_step) begin
            m_valid <= 1'b1;
            m_data  <= {quo_next, rem_next[WIDTH-1:0]};
          end
        end
        DONE: begin
          if (m_valid) begin
            m_valid <= 1'b0;
          end else begin
            // Divide by zero: quotient all-ones, remainder is the dividend
            // captured in the quotient register at accept.
            m_valid <= 1'b1;
            m_data  <= {{WIDTH{1'b1}}, quo_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_u32.sv
// Self-checking bench for div_iter_u32: directed vector table, hand-written
// corner sequences (operand noise during CALC, async reset mid-op) and random
// operations compared against a plain-arithmetic reference model.
module tb_div_iter_u32;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           m_valid;
  logic [2*W-1:0] m_data;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  div_iter_u32 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned division with the RISC-V divide-by-zero rule.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {{W{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  // Issue one operation and check latency, data, pulse width and handshake.
  // With noise set, s_valid is re-asserted with junk operands during CALC.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_data, input int exp_lat, input bit noise);
    int             edges;
    int             wait_cnt;
    bit             got;
    bit             ready_ok;
    bit             stable_ok;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] data;
    @(negedge clk);
    wait_cnt = 0;
    while (!s_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({name, " ready_before"}, 64'(s_ready), 64'd1);
    s_valid  = 1'b1;
    dividend = a;
    divisor  = b;
    prev     = m_data;
    @(posedge clk);
    edges     = 0;
    got       = 1'b0;
    ready_ok  = 1'b1;
    stable_ok = 1'b1;
    while (!got && edges < 100) begin
      @(negedge clk);
      if (m_valid) begin
        got = 1'b1;
      end else begin
        if (s_ready || !busy) ready_ok = 1'b0;
        if (m_data !== prev) stable_ok = 1'b0;
        s_valid  = noise && (edges + 1 < W - 4);
        dividend = $urandom;
        divisor  = $urandom;
        edges++;
      end
    end
    s_valid = 1'b0;
    data    = m_data;
    check({name, " got_valid"}, 64'(got), 64'd1);
    check({name, " latency"}, 64'(edges), 64'(exp_lat));
    check({name, " data"}, data, exp_data);
    check({name, " busy_no_ready"}, {63'd0, ready_ok}, 64'd1);
    check({name, " data_stable"}, {63'd0, stable_ok}, 64'd1);
    @(negedge clk);
    check({name, " pulse_end"}, {62'd0, m_valid, s_ready}, {62'd0, 1'b0, 1'b1});
    check({name, " data_hold"}, m_data, data);
  endtask

  vec_t vecs[6];
  int   pulses;

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    dividend = '0;
    divisor  = '0;
    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2, lat: W};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0, lat: W};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0, lat: W};
    vecs[3] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3, lat: W};
    vecs[4] = '{a: 32'h8000_0000,  b: 32'h10,         q: 32'h0800_0000,  r: 32'd0, lat: W};
    vecs[5] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5, lat: 1};

    #12;
    check("reset_state", {61'd0, s_ready, busy, m_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("reset_data", m_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r}, vecs[i].lat, 1'b0);

    // Normal op right after a divide-by-zero.
    run_op("after_div0", 32'd81, 32'd9, {32'd9, 32'd0}, W, 1'b0);

    // s_valid and operand changes during CALC must be ignored.
    run_op("noise", 32'd100, 32'd7, {32'd14, 32'd2}, W, 1'b1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid) pulses++;
    end
    check("noise_no_extra_pulse", 64'(pulses), 64'd0);

    // Asynchronous reset at step 10 of 100/7.
    @(negedge clk);
    s_valid  = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {61'd0, s_ready, busy, m_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("midreset_data", m_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_valid) pulses++;
    end
    check("midreset_no_pulse", 64'(pulses), 64'd0);
    run_op("after_reset", 32'd200, 32'd9, {32'd22, 32'd2}, W, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), a, b, ref_div(a, b), (b == '0) ? 1 : W, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter_u32.md
Name: div_iter_u32

Overview:
- Multi-cycle unsigned radix-2 restoring divider that replaces the vendor divider core inside the multiply/divide unit.
- Sits directly downstream of the mul_div operand-conditioning logic. That logic hands it magnitude-converted operands and does sign fix-up on the result itself.
- Handshake follows the existing stream style: one-cycle start strobe in, one-cycle valid pulse out, result packed {quotient, remainder}.
- Fixed, data-independent latency, so the issuing state machine and the pipeline stall logic stay simple.

Parameters:
WIDTH, 32, operand width in bits; quotient and remainder are each WIDTH bits.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  start strobe; operands valid this cycle
s_ready  output  1  divider idle, can accept an operation
dividend  input  WIDTH  unsigned dividend, sampled on accept edge only
divisor  input  WIDTH  unsigned divisor, sampled on accept edge only
m_valid  output  1  one-cycle pulse: m_data holds a new result
m_data  output  2*WIDTH  {quotient[WIDTH-1:0], remainder[WIDTH-1:0]}
busy  output  1  operation in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, m_valid=0, m_data=0, busy=0, s_ready=1.
  - Internal remainder, quotient and counter registers cleared.
- States: IDLE, CALC, DONE.
- s_ready=1 only in IDLE (combinational from state). busy=1 in CALC and DONE.
- Accept: rising edge with s_valid=1 and state=IDLE.
  - Latch divisor. Load quotient shift register with dividend. Clear the (WIDTH+1)-bit partial remainder. Clear step counter.
  - If divisor!=0, go to CALC. If divisor==0, go to DONE.
- s_valid while state!=IDLE is ignored; no queuing. Operand changes after the accept edge have no effect.
- CALC: one restoring step per edge.
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - {1'b0, divisor}, computed WIDTH+1 bits wide.
  - If trial is non-negative (MSB=0): rem=trial, quo[0]=1. Otherwise: rem=rem_shifted, quo[0]=0.
  - The counter increments each step. On the step where counter==WIDTH-1: go to DONE, load m_data={quo_next, rem_next[WIDTH-1:0]}, set m_valid=1 on the same edge.
- Latency:
  - m_valid is high in the cycle after the WIDTH-th rising edge following the accept edge (32 edges for WIDTH=32).
  - Divide by zero: m_valid is high in the cycle after the first edge following accept.
- Divide by zero: m_data={all-ones, dividend}, per the RISC-V unsigned rule. Registered on the accept edge and presented with m_valid.
- DONE: m_valid deasserts on the next edge and the state returns to IDLE. m_valid is always exactly one cycle wide; there is no backpressure.
- m_data holds its last value until the next result is loaded. It does not change on accept or during CALC.
- Back-to-back: the earliest next accept is the edge after DONE, so results are spaced at least WIDTH+2 cycles apart.
- Reset mid-operation: an asynchronous clear to the reset values. No m_valid pulse is produced for the aborted operation.
- Widths: no overflow is possible in unsigned division; the quotient is at most the dividend and the remainder is less than the divisor.

Test Plan:
- dividend=100, divisor=7 accepted -> m_valid exactly 32 edges later for one cycle, m_data={32'd14, 32'd2}; s_ready=0 from the accept until the cycle after m_valid.
- dividend=0xFFFFFFFF, divisor=1 -> quotient 0xFFFFFFFF, remainder 0. Then dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient 1, remainder 0.
- dividend=3, divisor=10 -> quotient 0, remainder 3. Then dividend=0x80000000, divisor=0x10 -> quotient 0x08000000, remainder 0.
- dividend=5, divisor=0 -> m_valid on the 1st edge after accept, m_data={0xFFFFFFFF, 32'd5}; the next op is accepted normally after DONE.
- Assert s_valid with new operands during CALC, and change dividend/divisor the cycle after accept -> both ignored; the first result is correct and exactly one m_valid pulse occurs.
- Pull rst_n low at step 10 of 100/7 (asynchronously, mid-cycle) -> outputs clear immediately, no m_valid. After release, 200/9 -> {22, 2} at full latency.
